ryuki_mem_arbiter: RTL



---
 rtl/ryuki_datatypes.sv | 5 +
 rtl/ryuki_mem_arbiter_if.sv | 42 ++++
 rtl/ryuki_mem_arbiter_fifo.sv | 52 +++++
 rtl/ryuki_mem_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/ryuki_datatypes.sv
// ryuki_datatypes: shared types for the Ryuki memory arbiter
package ryuki_datatypes;
    typedef enum logic {OWNER_INSTR, OWNER_DATA} mem_owner_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D} arb_state_t;
endpackage

// File: rtl/ryuki_mem_arbiter_if.sv
// ryuki_mem_arbiter_if: instruction, data and memory port bundle of the arbiter
interface ryuki_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    instr_req_i;
    logic [ADDR_WIDTH-1:0]   instr_addr_i;
    logic                    instr_gnt_o;
    logic                    instr_rvalid_o;
    logic [DATA_WIDTH-1:0]   instr_rdata_o;
    logic                    data_req_i;
    logic [ADDR_WIDTH-1:0]   data_addr_i;
    logic                    data_we_i;
    logic [DATA_WIDTH/8-1:0] data_be_i;
    logic [DATA_WIDTH-1:0]   data_wdata_i;
    logic                    data_gnt_o;
    logic                    data_rvalid_o;
    logic [DATA_WIDTH-1:0]   data_rdata_o;
    logic                    data_err_o;
    logic                    mem_req_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic                    mem_we_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;
    logic                    mem_err_i;
    logic                    protocol_err_o;
    modport slave (
        input  instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
               data_err_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, protocol_err_o
    );
    modport master (
        output instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
               data_err_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, protocol_err_o
    );
endinterface

// File: rtl/ryuki_mem_arbiter_fifo.sv
// arb_owner_fifo: in-order record of which requester owns each outstanding grant
module arb_owner_fifo
    import ryuki_datatypes::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  mem_owner_t owner_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       pop_empty_o,
    output mem_owner_t head_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    mem_owner_t    mem_q [DEPTH];
    mem_owner_t    mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign full_o      = cnt_q == CW'(DEPTH);
    assign empty_o     = cnt_q == '0;
    assign head_o      = mem_q[rd_q];
    assign pop_empty_o = pop_i & empty_o;
    always_comb begin
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = owner_i;
        wr_d  = do_push ? inc(wr_q) : wr_q;
        rd_d  = do_pop ? inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ryuki_mem_arbiter.sv
// ryuki_mem_arbiter: round-robin share of one memory port between fetch and data,
// with a lock until grant and an owner FIFO steering responses back in order
module ryuki_mem_arbiter
    import ryuki_datatypes::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk_i,
    input logic rst_i,
    ryuki_mem_arbiter_if.slave bus
);
    arb_state_t            state_q, state_d;
    mem_owner_t            last_q, last_d, sel, head;
    logic                  sel_valid, mem_req, grant, resp, full, empty, pop_empty, perr_q, perr_d;
    logic [ADDR_WIDTH-1:0] addr_sel;
    always_comb begin
        sel       = OWNER_INSTR;
        sel_valid = 1'b0;
        case (state_q)
            ARB_LOCK_I: sel_valid = bus.instr_req_i;
            ARB_LOCK_D: begin
                sel       = OWNER_DATA;
                sel_valid = bus.data_req_i;
            end
            default: begin
                sel_valid = bus.instr_req_i | bus.data_req_i;
                sel = (bus.instr_req_i && bus.data_req_i) ? (last_q == OWNER_DATA ? OWNER_INSTR : OWNER_DATA)
                    : (bus.data_req_i ? OWNER_DATA : OWNER_INSTR);
            end
        endcase
        mem_req = sel_valid & ~full & ~rst_i;
        grant   = mem_req & bus.mem_gnt_i;
        resp    = bus.mem_rvalid_i & ~empty & ~rst_i;
        // Lock only when a request was actually presented and left waiting
        state_d = state_q;
        if (state_q == ARB_IDLE)
            state_d = (mem_req && !bus.mem_gnt_i) ? (sel == OWNER_DATA ? ARB_LOCK_D : ARB_LOCK_I) : ARB_IDLE;
        else if (grant || !sel_valid)
            state_d = ARB_IDLE;
        last_d   = grant ? sel : last_q;
        perr_d   = perr_q | pop_empty;
        addr_sel = sel == OWNER_DATA ? bus.data_addr_i : bus.instr_addr_i;
    end
    arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (grant),
        .pop_i      (bus.mem_rvalid_i),
        .owner_i    (sel),
        .full_o     (full),
        .empty_o    (empty),
        .pop_empty_o(pop_empty),
        .head_o     (head)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            last_q  <= OWNER_DATA;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
        end
    end
    assign bus.mem_req_o      = mem_req;
    assign bus.mem_addr_o     = addr_sel;
    assign bus.mem_we_o       = (sel == OWNER_DATA) & bus.data_we_i;
    assign bus.mem_be_o       = sel == OWNER_DATA ? bus.data_be_i : {(DATA_WIDTH/8){1'b1}};
    assign bus.mem_wdata_o    = sel == OWNER_DATA ? bus.data_wdata_i : {DATA_WIDTH{1'b0}};
    assign bus.instr_gnt_o    = grant & (sel == OWNER_INSTR);
    assign bus.data_gnt_o     = grant & (sel == OWNER_DATA);
    assign bus.instr_rvalid_o = resp & (head == OWNER_INSTR);
    assign bus.data_rvalid_o  = resp & (head == OWNER_DATA);
    assign bus.data_err_o     = bus.data_rvalid_o & bus.mem_err_i;
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;
    assign bus.protocol_err_o = perr_q;
endmodule
